// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, set-unit selects,
// PC-decision codes and operand-source selects.
package ex_stage_pkg;

    localparam int DW = 16;

    typedef enum logic [2:0] {
        ALU_ROL = 3'b000,
        ALU_SLL = 3'b001,
        ALU_ROR = 3'b010,
        ALU_SRL = 3'b011,
        ALU_ADD = 3'b100,
        ALU_OR  = 3'b101,
        ALU_XOR = 3'b110,
        ALU_AND = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SET_SEQ = 2'b00,
        SET_SLT = 2'b01,
        SET_SLE = 2'b10,
        SET_SCO = 2'b11
    } set_sel_e;

    typedef enum logic [1:0] {
        PC_NONE   = 2'b00,
        PC_JUMP   = 2'b01,
        PC_JR     = 2'b10,
        PC_BRANCH = 2'b11
    } pc_dec_e;

    typedef enum logic [1:0] {
        SRCA_REG    = 2'b00,
        SRCA_REG_HI = 2'b01,
        SRCA_ZERO   = 2'b10,
        SRCA_PC     = 2'b11
    } srca_e;

    typedef enum logic [1:0] {
        SRCB_REG   = 2'b00,
        SRCB_IMM   = 2'b01,
        SRCB_ZERO  = 2'b10,
        SRCB_ZERO2 = 2'b11
    } srcb_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM registered outputs of the execute stage.
// master drives the decoded instruction; slave is the execute stage itself.
interface ex_stage_if #(
    parameter int DW = 16,
    parameter int RW = 3
);
    logic          ex_alu_res_sel, ex_branch, ex_branch_eqz, ex_branch_gtz, ex_branch_ltz;
    logic          ex_Cin, ex_invA, ex_invB, ex_sign_alu;
    logic          ex_memEn, ex_memWrite, ex_regWrite, ex_createdump, ex_halt;
    logic [1:0]    ex_ALUSrc_a, ex_ALUSrc_b, ex_memToReg, ex_pc_dec, ex_set_select;
    logic [2:0]    ex_alu_op;
    logic [RW-1:0] ex_write_reg;
    logic [DW-1:0] ex_reg1_data, ex_reg2_data, ex_sign_ext_low_bits, ex_pc_plus;

    logic [DW-1:0] mem_alu_result, mem_wr_data, mem_pc_plus;
    logic [RW-1:0] mem_write_reg;
    logic          mem_regWrite, mem_memEn, mem_memWrite, mem_halt, mem_createdump;
    logic [1:0]    mem_memToReg;

    modport master (
        output ex_alu_res_sel, ex_branch, ex_branch_eqz, ex_branch_gtz, ex_branch_ltz,
               ex_Cin, ex_invA, ex_invB, ex_sign_alu,
               ex_memEn, ex_memWrite, ex_regWrite, ex_createdump, ex_halt,
               ex_ALUSrc_a, ex_ALUSrc_b, ex_memToReg, ex_pc_dec, ex_set_select,
               ex_alu_op, ex_write_reg,
               ex_reg1_data, ex_reg2_data, ex_sign_ext_low_bits, ex_pc_plus,
        input  mem_alu_result, mem_wr_data, mem_pc_plus, mem_write_reg,
               mem_regWrite, mem_memEn, mem_memWrite, mem_halt, mem_createdump, mem_memToReg
    );

    modport slave (
        input  ex_alu_res_sel, ex_branch, ex_branch_eqz, ex_branch_gtz, ex_branch_ltz,
               ex_Cin, ex_invA, ex_invB, ex_sign_alu,
               ex_memEn, ex_memWrite, ex_regWrite, ex_createdump, ex_halt,
               ex_ALUSrc_a, ex_ALUSrc_b, ex_memToReg, ex_pc_dec, ex_set_select,
               ex_alu_op, ex_write_reg,
               ex_reg1_data, ex_reg2_data, ex_sign_ext_low_bits, ex_pc_plus,
        output mem_alu_result, mem_wr_data, mem_pc_plus, mem_write_reg,
               mem_regWrite, mem_memEn, mem_memWrite, mem_halt, mem_createdump, mem_memToReg
    );

endinterface

// File: rtl/ex_alu.sv
// Combinational ALU (rotates, shifts, add, logic) plus set unit; operands
// arrive already selected and inverted. Latency 0, no backpressure.
module ex_alu
    import ex_stage_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          cin,
    input  logic [2:0]    alu_op,
    input  logic [1:0]    set_select,
    input  logic          sign_alu,
    input  logic          alu_res_sel,
    output logic [DW-1:0] result
);
    logic [3:0]    shamt;
    logic [DW:0]   sum;
    logic [DW-1:0] alu_res, set_res;
    logic          eq, lt;

    assign shamt = b[3:0];
    assign sum   = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
    assign eq    = (a == b);
    assign lt    = sign_alu ? ($signed(a) < $signed(b)) : (a < b);

    // a >> DW yields zero, so a zero rotate amount falls out naturally
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ROL: alu_res = (a << shamt) | (a >> (DW - int'(shamt)));
            ALU_SLL: alu_res = a << shamt;
            ALU_ROR: alu_res = (a >> shamt) | (a << (DW - int'(shamt)));
            ALU_SRL: alu_res = a >> shamt;
            ALU_ADD: alu_res = sum[DW-1:0];
            ALU_OR:  alu_res = a | b;
            ALU_XOR: alu_res = a ^ b;
            ALU_AND: alu_res = a & b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        set_res = '0;
        case (set_select)
            SET_SEQ: set_res[0] = eq;
            SET_SLT: set_res[0] = lt;
            SET_SLE: set_res[0] = lt | eq;
            SET_SCO: set_res[0] = sum[DW];
            default: set_res = '0;
        endcase
    end

    assign result = alu_res_sel ? set_res : alu_res;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, optional forwarding (EX_FWD_EN), ALU, branch resolution.
// Latency 1 cycle into EX/MEM; ex_stall holds EX/MEM; redirect fires once per stalled transfer.
module ex_stage #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_stall,
`ifdef EX_FWD_EN
    input  logic [1:0]    fwd_a_sel,
    input  logic [1:0]    fwd_b_sel,
    input  logic [DW-1:0] wb_data,
`endif
    ex_stage_if.slave     bus,
    output logic          redirect,
    output logic [DW-1:0] redirect_pc
);
    import ex_stage_pkg::*;

    logic [DW-1:0] r1, r2, op_a, op_b, a_fin, b_fin, alu_out, imm, pc_plus;
    logic [RW-1:0] wr_idx;
    logic          r1_zero, r1_neg, r1_pos, br_taken, xfer;
    logic          halt_seen, redir_done;

    assign imm     = bus.ex_sign_ext_low_bits;
    assign pc_plus = bus.ex_pc_plus;
    assign wr_idx  = bus.ex_write_reg;

`ifdef EX_FWD_EN
    always_comb begin
        r1 = bus.ex_reg1_data;
        r2 = bus.ex_reg2_data;
        case (fwd_a_sel)
            2'b01:   r1 = bus.mem_alu_result;
            2'b10:   r1 = wb_data;
            default: r1 = bus.ex_reg1_data;
        endcase
        case (fwd_b_sel)
            2'b01:   r2 = bus.mem_alu_result;
            2'b10:   r2 = wb_data;
            default: r2 = bus.ex_reg2_data;
        endcase
    end
`else
    assign r1 = bus.ex_reg1_data;
    assign r2 = bus.ex_reg2_data;
`endif

    always_comb begin
        op_a = '0;
        op_b = '0;
        case (bus.ex_ALUSrc_a)
            SRCA_REG:    op_a = r1;
            SRCA_REG_HI: op_a = r1 << 8;
            SRCA_ZERO:   op_a = '0;
            SRCA_PC:     op_a = pc_plus;
            default:     op_a = '0;
        endcase
        case (bus.ex_ALUSrc_b)
            SRCB_REG: op_b = r2;
            SRCB_IMM: op_b = imm;
            default:  op_b = '0;
        endcase
    end

    assign a_fin = bus.ex_invA ? ~op_a : op_a;
    assign b_fin = bus.ex_invB ? ~op_b : op_b;

    ex_alu u_alu (
        .a           (a_fin),
        .b           (b_fin),
        .cin         (bus.ex_Cin),
        .alu_op      (bus.ex_alu_op),
        .set_select  (bus.ex_set_select),
        .sign_alu    (bus.ex_sign_alu),
        .alu_res_sel (bus.ex_alu_res_sel),
        .result      (alu_out)
    );

    assign r1_zero  = (r1 == '0);
    assign r1_neg   = r1[DW-1];
    assign r1_pos   = !r1_zero && !r1_neg;
    assign br_taken = bus.ex_branch && ((bus.ex_branch_eqz && r1_zero) ||
                                        (bus.ex_branch_gtz && r1_pos)  ||
                                        (bus.ex_branch_ltz && r1_neg));

    always_comb begin
        xfer        = 1'b0;
        redirect_pc = pc_plus + imm;
        case (bus.ex_pc_dec)
            PC_JUMP:   xfer = 1'b1;
            PC_JR: begin
                xfer        = 1'b1;
                redirect_pc = r1 + imm;
            end
            PC_BRANCH: xfer = br_taken;
            default:   xfer = 1'b0;
        endcase
    end

    // Once halted, younger instructions must not steer fetch
    assign redirect = xfer && !redir_done && !halt_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_alu_result <= '0;
            bus.mem_wr_data    <= '0;
            bus.mem_pc_plus    <= '0;
            bus.mem_write_reg  <= '0;
            bus.mem_regWrite   <= 1'b0;
            bus.mem_memEn      <= 1'b0;
            bus.mem_memWrite   <= 1'b0;
            bus.mem_halt       <= 1'b0;
            bus.mem_createdump <= 1'b0;
            bus.mem_memToReg   <= '0;
            halt_seen          <= 1'b0;
            redir_done         <= 1'b0;
        end else begin
            if (ex_stall) begin
                if (redirect)
                    redir_done <= 1'b1;
            end else begin
                redir_done <= 1'b0;
            end

            if (!ex_stall) begin
                if (halt_seen) begin
                    bus.mem_regWrite   <= 1'b0;
                    bus.mem_memEn      <= 1'b0;
                    bus.mem_memWrite   <= 1'b0;
                    bus.mem_halt       <= 1'b0;
                    bus.mem_createdump <= 1'b0;
                    bus.mem_memToReg   <= '0;
                end else begin
                    bus.mem_alu_result <= alu_out;
                    bus.mem_wr_data    <= r2;
                    bus.mem_pc_plus    <= pc_plus;
                    bus.mem_write_reg  <= wr_idx;
                    bus.mem_regWrite   <= bus.ex_regWrite;
                    bus.mem_memEn      <= bus.ex_memEn;
                    bus.mem_memWrite   <= bus.ex_memWrite;
                    bus.mem_halt       <= bus.ex_halt;
                    bus.mem_createdump <= bus.ex_createdump;
                    bus.mem_memToReg   <= bus.ex_memToReg;
                    if (bus.ex_halt)
                        halt_seen <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage; forwarding steps are compiled in with EX_FWD_EN.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    int          errors = 0;
    int          checks = 0;
`ifdef EX_FWD_EN
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] wb_data;
`endif

    ex_stage_if #(.DW(16), .RW(3)) bus ();

    ex_stage #(.DW(16), .RW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_stall    (ex_stall),
`ifdef EX_FWD_EN
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .wb_data     (wb_data),
`endif
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.ex_alu_res_sel = 0; bus.ex_branch = 0; bus.ex_branch_eqz = 0;
        bus.ex_branch_gtz = 0; bus.ex_branch_ltz = 0; bus.ex_Cin = 0;
        bus.ex_invA = 0; bus.ex_invB = 0; bus.ex_sign_alu = 0;
        bus.ex_memEn = 0; bus.ex_memWrite = 0; bus.ex_regWrite = 0;
        bus.ex_createdump = 0; bus.ex_halt = 0;
        bus.ex_ALUSrc_a = 0; bus.ex_ALUSrc_b = 0; bus.ex_memToReg = 0;
        bus.ex_pc_dec = 0; bus.ex_set_select = 0; bus.ex_alu_op = 0;
        bus.ex_write_reg = 0; bus.ex_reg1_data = 0; bus.ex_reg2_data = 0;
        bus.ex_sign_ext_low_bits = 0; bus.ex_pc_plus = 0;
`ifdef EX_FWD_EN
        fwd_a_sel = 0; fwd_b_sel = 0; wb_data = 0;
`endif
    endtask

    // ALU vector: operand A = reg1, operand B from reg2/imm per srcb
    task automatic alu_vec(input string tag, input logic [15:0] r1, input logic [15:0] r2,
                           input logic [15:0] imm, input logic [1:0] srca, input logic [1:0] srcb,
                           input logic [2:0] op, input logic [15:0] exp);
        clear();
        bus.ex_reg1_data = r1; bus.ex_reg2_data = r2; bus.ex_sign_ext_low_bits = imm;
        bus.ex_ALUSrc_a = srca; bus.ex_ALUSrc_b = srcb; bus.ex_alu_op = op;
        tick();
        chk(tag, {16'h0, bus.mem_alu_result}, {16'h0, exp});
    endtask

    initial begin
        rst = 1; ex_stall = 0;
        clear();
        tick(); tick();
        chk("rst_alu",      {16'h0, bus.mem_alu_result}, 32'h0);
        chk("rst_regwrite", {31'h0, bus.mem_regWrite},   32'h0);
        chk("rst_halt",     {31'h0, bus.mem_halt},       32'h0);
        chk("rst_memtoreg", {30'h0, bus.mem_memToReg},   32'h0);
        chk("rst_redirect", {31'h0, redirect},           32'h0);
        rst = 0;

        // ADD with one-cycle latency
        clear();
        bus.ex_reg1_data = 16'h7FFF; bus.ex_reg2_data = 16'h0001; bus.ex_alu_op = 3'b100;
        bus.ex_regWrite = 1; bus.ex_write_reg = 3'd3; bus.ex_memToReg = 2'b01;
        #1;
        chk("add_latency", {16'h0, bus.mem_alu_result}, 32'h0);
        tick();
        chk("add_res",      {16'h0, bus.mem_alu_result}, 32'h8000);
        chk("add_regwrite", {31'h0, bus.mem_regWrite},   32'h1);
        chk("add_wreg",     {29'h0, bus.mem_write_reg},  32'h3);
        chk("add_wrdata",   {16'h0, bus.mem_wr_data},    32'h0001);
        chk("add_memtoreg", {30'h0, bus.mem_memToReg},   32'h1);

        // B - A via inverted A plus carry-in
        clear();
        bus.ex_reg1_data = 16'd5; bus.ex_reg2_data = 16'd3; bus.ex_alu_op = 3'b100;
        bus.ex_invA = 1; bus.ex_Cin = 1;
        tick();
        chk("sub", {16'h0, bus.mem_alu_result}, 32'hFFFE);

        // Set unit
        clear();
        bus.ex_reg1_data = 16'hFFFF; bus.ex_reg2_data = 16'h0001;
        bus.ex_alu_res_sel = 1; bus.ex_set_select = 2'b01; bus.ex_sign_alu = 1;
        tick();
        chk("slt_signed", {16'h0, bus.mem_alu_result}, 32'h0001);
        bus.ex_sign_alu = 0;
        tick();
        chk("slt_unsigned", {16'h0, bus.mem_alu_result}, 32'h0000);
        bus.ex_set_select = 2'b11;
        tick();
        chk("sco", {16'h0, bus.mem_alu_result}, 32'h0001);
        bus.ex_reg1_data = 16'd5; bus.ex_reg2_data = 16'd5; bus.ex_set_select = 2'b10;
        tick();
        chk("sle_eq", {16'h0, bus.mem_alu_result}, 32'h0001);
        bus.ex_reg2_data = 16'd6; bus.ex_set_select = 2'b00;
        tick();
        chk("seq_ne", {16'h0, bus.mem_alu_result}, 32'h0000);

        // Shifts, rotates, logic, operand-A high-byte select
        alu_vec("rol", 16'h8001, 16'h0, 16'd1,  2'b00, 2'b01, 3'b000, 16'h0003);
        alu_vec("sll", 16'h0001, 16'h0, 16'd15, 2'b00, 2'b01, 3'b001, 16'h8000);
        alu_vec("ror", 16'h1234, 16'h0, 16'd4,  2'b00, 2'b01, 3'b010, 16'h4123);
        alu_vec("srl", 16'h8000, 16'h0, 16'd15, 2'b00, 2'b01, 3'b011, 16'h0001);
        alu_vec("hi_or", 16'h0012, 16'h0, 16'h0, 2'b01, 2'b10, 3'b101, 16'h1200);
        alu_vec("xor", 16'hF0F0, 16'hFF00, 16'h0, 2'b00, 2'b00, 3'b110, 16'h0FF0);
        alu_vec("and", 16'hF0F0, 16'hFF00, 16'h0, 2'b00, 2'b00, 3'b111, 16'hF000);
        alu_vec("pc_zero_add", 16'h0, 16'h0, 16'h0, 2'b11, 2'b10, 3'b100, 16'h0000);

        // Branch resolution (combinational)
        clear();
        bus.ex_branch = 1; bus.ex_branch_eqz = 1; bus.ex_reg1_data = 16'h0;
        bus.ex_pc_plus = 16'h0010; bus.ex_sign_ext_low_bits = 16'h0006; bus.ex_pc_dec = 2'b11;
        #1;
        chk("beqz_taken", {31'h0, redirect},     32'h1);
        chk("beqz_pc",    {16'h0, redirect_pc},  32'h0016);
        bus.ex_reg1_data = 16'h0001;
        #1;
        chk("beqz_not", {31'h0, redirect}, 32'h0);
        bus.ex_branch_eqz = 0; bus.ex_branch_gtz = 1;
        #1;
        chk("bgtz_taken", {31'h0, redirect}, 32'h1);
        bus.ex_branch_gtz = 0; bus.ex_branch_ltz = 1; bus.ex_reg1_data = 16'h8000;
        #1;
        chk("bltz_taken", {31'h0, redirect}, 32'h1);
        bus.ex_reg1_data = 16'h0000;
        #1;
        chk("bltz_zero", {31'h0, redirect}, 32'h0);
        tick();

        // Stalled JR: redirect exactly once, EX/MEM held
        clear();
        bus.ex_reg1_data = 16'd1; bus.ex_reg2_data = 16'd1; bus.ex_alu_op = 3'b100; bus.ex_regWrite = 1;
        tick();
        clear();
        bus.ex_reg1_data = 16'h0100; bus.ex_sign_ext_low_bits = 16'd4; bus.ex_pc_dec = 2'b10;
        ex_stall = 1;
        #1;
        chk("jr_stall_c1",  {31'h0, redirect},    32'h1);
        chk("jr_pc",        {16'h0, redirect_pc}, 32'h0104);
        tick();
        chk("jr_stall_c2",  {31'h0, redirect},    32'h0);
        tick();
        chk("jr_stall_c3",  {31'h0, redirect},    32'h0);
        chk("jr_hold_alu",  {16'h0, bus.mem_alu_result}, 32'h0002);
        chk("jr_hold_rw",   {31'h0, bus.mem_regWrite},   32'h1);
        tick();
        ex_stall = 0;
        #1;
        chk("jr_release", {31'h0, redirect}, 32'h0);
        tick();
        chk("jr_retire_alu", {16'h0, bus.mem_alu_result}, 32'h0100);
        chk("jr_retire_rw",  {31'h0, bus.mem_regWrite},   32'h0);

        // Unstalled jump after the stall redirects again
        clear();
        bus.ex_pc_plus = 16'h0020; bus.ex_sign_ext_low_bits = 16'd2; bus.ex_pc_dec = 2'b01;
        bus.ex_reg1_data = 16'd3; bus.ex_reg2_data = 16'd4; bus.ex_alu_op = 3'b100;
        bus.ex_regWrite = 1; bus.ex_memEn = 1;
        #1;
        chk("jump_redirect", {31'h0, redirect},    32'h1);
        chk("jump_pc",       {16'h0, redirect_pc}, 32'h0022);
        tick();
        chk("jump_alu", {16'h0, bus.mem_alu_result}, 32'h0007);

        // Reset during a stalled JR clears EX/MEM and redir_done
        clear();
        bus.ex_reg1_data = 16'h0100; bus.ex_sign_ext_low_bits = 16'd4; bus.ex_pc_dec = 2'b10;
        ex_stall = 1;
        tick();
        chk("rs_redir_done", {31'h0, redirect},     32'h0);
        chk("rs_pre_memen",  {31'h0, bus.mem_memEn}, 32'h1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("rs_alu",      {16'h0, bus.mem_alu_result}, 32'h0);
        chk("rs_regwrite", {31'h0, bus.mem_regWrite},   32'h0);
        chk("rs_memen",    {31'h0, bus.mem_memEn},      32'h0);
        chk("rs_reredir",  {31'h0, redirect},           32'h1);
        ex_stall = 0;
        tick();

        // Halt then a younger instruction becomes a bubble
        clear();
        bus.ex_halt = 1; bus.ex_createdump = 1;
        tick();
        chk("halt_mem",     {31'h0, bus.mem_halt},       32'h1);
        chk("halt_dump",    {31'h0, bus.mem_createdump}, 32'h1);
        clear();
        bus.ex_regWrite = 1; bus.ex_reg1_data = 16'd1; bus.ex_reg2_data = 16'd1; bus.ex_alu_op = 3'b100;
        bus.ex_pc_dec = 2'b01; bus.ex_pc_plus = 16'h0040; bus.ex_sign_ext_low_bits = 16'd2;
        #1;
        chk("halt_no_redir", {31'h0, redirect}, 32'h0);
        tick();
        chk("bubble_rw",   {31'h0, bus.mem_regWrite}, 32'h0);
        chk("bubble_halt", {31'h0, bus.mem_halt},     32'h0);

`ifdef EX_FWD_EN
        rst = 1;
        tick();
        rst = 0;
        clear();
        fwd_a_sel = 2'b10; wb_data = 16'h1234; bus.ex_ALUSrc_b = 2'b10; bus.ex_alu_op = 3'b100;
        tick();
        chk("fwd_wb", {16'h0, bus.mem_alu_result}, 32'h1234);
        clear();
        fwd_a_sel = 2'b01; fwd_b_sel = 2'b10; wb_data = 16'h0001; bus.ex_alu_op = 3'b100;
        tick();
        chk("fwd_exmem", {16'h0, bus.mem_alu_result}, 32'h1235);
        chk("fwd_wrdata", {16'h0, bus.mem_wr_data},   32'h0001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
